// File: rtl/tiny_nn_arb.sv
// Round-robin job arbiter sharing one tiny_nn_top core between two word-streaming requesters.
// Optional stall watchdog compiled in with `define TINY_NN_ARB_WATCHDOG_EN.
module tiny_nn_arb #(
   parameter int unsigned DrainCycles    = 6,
   parameter logic [15:0] IdleWord       = 16'h0000,
   parameter int unsigned WatchdogCycles = 255,
   parameter logic [15:0] TermWord       = 16'h7fff
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  req_valid_i,
   input  logic [1:0]  req_last_i,
   input  logic [31:0] req_data_i,
   output logic [1:0]  req_ready_o,
   output logic [15:0] core_data_o,
   input  logic [7:0]  core_data_i,
   output logic [1:0]  rsp_valid_o,
   output logic [7:0]  rsp_data_o,
   output logic [1:0]  grant_o,
   output logic [1:0]  err_o,
   input  logic        err_clr_i
);

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_DRAIN
   } arb_state_e;

   arb_state_e  state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        prio_q, prio_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  err_q, err_d, err_set;
   logic [15:0] core_data_q, core_data_d;
   logic        owner;
   logic        owner_valid;
   logic        owner_last;
   logic [15:0] owner_data;
   logic        wd_hit;

   assign owner       = grant_q[1];
   assign owner_valid = req_valid_i[owner];
   assign owner_last  = req_last_i[owner];
   assign owner_data  = owner ? req_data_i[31:16] : req_data_i[15:0];

`ifdef TINY_NN_ARB_WATCHDOG_EN
   logic [7:0] wd_q;

   assign wd_hit = (state_q == ARB_BUSY) && (wd_q == 8'(WatchdogCycles));

   // Counts granted cycles of the current job; zero whenever no job is streaming.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q <= '0;
      end else if (state_q == ARB_BUSY) begin
         wd_q <= wd_q + 8'd1;
      end else begin
         wd_q <= '0;
      end
   end
`else
   // Keeps the watchdog limit referenced in builds without the watchdog.
   assign wd_hit = (WatchdogCycles == 0) && 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      prio_d      = prio_q;
      cnt_d       = cnt_q;
      core_data_d = IdleWord;
      err_set     = 2'b00;
      req_ready_o = 2'b00;
      case (state_q)
         ARB_IDLE: begin
            if (|req_valid_i) begin
               state_d = ARB_BUSY;
               case (req_valid_i)
                  2'b01:   grant_d = 2'b01;
                  2'b10:   grant_d = 2'b10;
                  default: grant_d = prio_q ? 2'b10 : 2'b01;
               endcase
            end
         end
         ARB_BUSY: begin
            if (wd_hit) begin
               core_data_d = TermWord;
               err_set[1]  = 1'b1;
               state_d     = ARB_DRAIN;
               cnt_d       = 8'(DrainCycles - 1);
            end else begin
               req_ready_o = grant_q;
               if (owner_valid) begin
                  core_data_d = owner_data;
                  if (owner_last) begin
                     state_d = ARB_DRAIN;
                     cnt_d   = 8'(DrainCycles - 1);
                  end
               end else begin
                  err_set[0] = 1'b1;
               end
            end
         end
         ARB_DRAIN: begin
            // The owner just finished, so the other requester wins the next tie.
            if (cnt_q == 8'd0) begin
               state_d = ARB_IDLE;
               grant_d = 2'b00;
               prio_d  = ~owner;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = 2'b00;
         end
      endcase
      err_d = err_clr_i ? 2'b00 : (err_q | err_set);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ARB_IDLE;
         grant_q     <= 2'b00;
         prio_q      <= 1'b0;
         cnt_q       <= 8'd0;
         err_q       <= 2'b00;
         core_data_q <= IdleWord;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         core_data_q <= core_data_d;
      end
   end

   assign core_data_o = core_data_q;
   assign grant_o     = grant_q;
   assign err_o       = err_q;
   assign rsp_valid_o = (state_q == ARB_IDLE) ? 2'b00 : grant_q;
   assign rsp_data_o  = core_data_i;

endmodule

// File: tb/tb_tiny_nn_arb.sv
// Directed bench for tiny_nn_arb: single job, round-robin contention, bubbles,
// response steering, watchdog (or its absence) and asynchronous reset mid-drain.
module tb_tiny_nn_arb;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_last_i;
   logic [31:0] req_data_i;
   logic [1:0]  req_ready_o;
   logic [15:0] core_data_o;
   logic [7:0]  core_data_i;
   logic [1:0]  rsp_valid_o;
   logic [7:0]  rsp_data_o;
   logic [1:0]  grant_o;
   logic [1:0]  err_o;
   logic        err_clr_i;

   int n_compared   = 0;
   int n_mismatched = 0;

   tiny_nn_arb #(
      .DrainCycles   (6),
      .IdleWord      (16'h0000),
      .WatchdogCycles(4),
      .TermWord      (16'h7fff)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_valid_i(req_valid_i),
      .req_last_i (req_last_i),
      .req_data_i (req_data_i),
      .req_ready_o(req_ready_o),
      .core_data_o(core_data_o),
      .core_data_i(core_data_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_data_o (rsp_data_o),
      .grant_o    (grant_o),
      .err_o      (err_o),
      .err_clr_i  (err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] last,
                                input logic [15:0] d0, input logic [15:0] d1);
      req_valid_i = valid;
      req_last_i  = last;
      req_data_i  = {d1, d0};
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " grant"},     32'(grant_o),     32'h0);
      checkOutput({tag, " core_data"}, 32'(core_data_o), 32'h0);
      checkOutput({tag, " err"},       32'(err_o),       32'h0);
      checkOutput({tag, " ready"},     32'(req_ready_o), 32'h0);
      checkOutput({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'h0);
   endtask

   // Six drain idle words; grant drops in the sixth cycle when the arbiter is idle again.
   task automatic drainOut(input string tag, input logic [1:0] owner);
      logic [1:0] exp_grant;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_grant = (i == 6) ? 2'b00 : owner;
         checkOutput({tag, " drain word"}, 32'(core_data_o), 32'h0);
         checkOutput({tag, " drain grant"}, 32'(grant_o), 32'(exp_grant));
         checkOutput({tag, " drain rsp_valid"}, 32'(rsp_valid_o), 32'(exp_grant));
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      err_clr_i   = 1'b0;
      core_data_i = 8'h3c;
      applyStimulus(2'b11, 2'b00, 16'h0a01, 16'h0b01);
      repeat (2) tick();
      checkReset("por");
      rst_ni = 1'b1;

      // Contention from reset: requester 0, then 1, then 0 again.
      tick();
      checkOutput("rr grant0", 32'(grant_o), 32'h1);
      checkOutput("rr ready0", 32'(req_ready_o), 32'h1);
      checkOutput("rr rsp_data", 32'(rsp_data_o), 32'h3c);
      tick();
      checkOutput("rr word0a01", 32'(core_data_o), 32'h0a01);
      applyStimulus(2'b11, 2'b01, 16'h0a02, 16'h0b01);
      tick();
      checkOutput("rr word0a02", 32'(core_data_o), 32'h0a02);
      checkOutput("rr ready drain", 32'(req_ready_o), 32'h0);
      applyStimulus(2'b11, 2'b00, 16'h0a03, 16'h0b01);
      drainOut("rr job0", 2'b01);
      tick();
      checkOutput("rr grant1", 32'(grant_o), 32'h2);
      checkOutput("rr ready1", 32'(req_ready_o), 32'h2);
      tick();
      checkOutput("rr word0b01", 32'(core_data_o), 32'h0b01);
      applyStimulus(2'b11, 2'b10, 16'h0a03, 16'h0b02);
      tick();
      checkOutput("rr word0b02", 32'(core_data_o), 32'h0b02);
      applyStimulus(2'b11, 2'b00, 16'h0a03, 16'h0b03);
      drainOut("rr job1", 2'b10);
      tick();
      checkOutput("rr grant0 again", 32'(grant_o), 32'h1);
      applyStimulus(2'b11, 2'b01, 16'h0a03, 16'h0b03);
      tick();
      checkOutput("rr word0a03", 32'(core_data_o), 32'h0a03);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      drainOut("rr job2", 2'b01);

      // Single three-word job from requester 0.
      applyStimulus(2'b01, 2'b00, 16'h1234, 16'h0000);
      checkOutput("job ready idle", 32'(req_ready_o), 32'h0);
      tick();
      checkOutput("job grant", 32'(grant_o), 32'h1);
      checkOutput("job ready", 32'(req_ready_o), 32'h1);
      checkOutput("job idle word", 32'(core_data_o), 32'h0);
      tick();
      checkOutput("job word1234", 32'(core_data_o), 32'h1234);
      applyStimulus(2'b01, 2'b00, 16'h5678, 16'h0000);
      tick();
      checkOutput("job word5678", 32'(core_data_o), 32'h5678);
      applyStimulus(2'b01, 2'b01, 16'h7fff, 16'h0000);
      tick();
      checkOutput("job word7fff", 32'(core_data_o), 32'h7fff);
      checkOutput("job rsp_valid", 32'(rsp_valid_o), 32'h1);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      drainOut("job", 2'b01);

      // Requester 1 with a two-cycle bubble; response steering.
      core_data_i = 8'ha5;
      applyStimulus(2'b10, 2'b00, 16'h0000, 16'h2001);
      tick();
      checkOutput("bub grant", 32'(grant_o), 32'h2);
      checkOutput("bub rsp_valid", 32'(rsp_valid_o), 32'h2);
      checkOutput("bub rsp_data", 32'(rsp_data_o), 32'ha5);
      tick();
      checkOutput("bub word2001", 32'(core_data_o), 32'h2001);
      checkOutput("bub err clean", 32'(err_o), 32'h0);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h2001);
      tick();
      checkOutput("bub idle1", 32'(core_data_o), 32'h0);
      checkOutput("bub err set", 32'(err_o), 32'h1);
      checkOutput("bub ready held", 32'(req_ready_o), 32'h2);
      tick();
      checkOutput("bub idle2", 32'(core_data_o), 32'h0);
      applyStimulus(2'b10, 2'b10, 16'h0000, 16'h2002);
      tick();
      checkOutput("bub word2002", 32'(core_data_o), 32'h2002);
      checkOutput("bub rsp_valid drain", 32'(rsp_valid_o), 32'h2);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      drainOut("bub", 2'b10);
      checkOutput("bub err sticky", 32'(err_o), 32'h1);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      checkOutput("bub err cleared", 32'(err_o), 32'h0);

      // Job from requester 0 that never raises last.
      applyStimulus(2'b01, 2'b00, 16'h3001, 16'h0000);
      tick();
      checkOutput("wd grant", 32'(grant_o), 32'h1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checkOutput("wd word", 32'(core_data_o), 32'(16'h3000 + 16'(k)));
         applyStimulus(2'b01, 2'b00, 16'h3000 + 16'(k + 1), 16'h0000);
      end
`ifdef TINY_NN_ARB_WATCHDOG_EN
      checkOutput("wd ready blocked", 32'(req_ready_o), 32'h0);
      tick();
      checkOutput("wd term word", 32'(core_data_o), 32'h7fff);
      checkOutput("wd err", 32'(err_o), 32'h2);
      checkOutput("wd grant drain", 32'(grant_o), 32'h1);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      drainOut("wd", 2'b01);
`else
      checkOutput("nowd ready", 32'(req_ready_o), 32'h1);
      tick();
      checkOutput("nowd word3005", 32'(core_data_o), 32'h3005);
      checkOutput("nowd err", 32'(err_o), 32'h0);
      checkOutput("nowd grant", 32'(grant_o), 32'h1);
      applyStimulus(2'b01, 2'b01, 16'h3006, 16'h0000);
      tick();
      checkOutput("nowd word3006", 32'(core_data_o), 32'h3006);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      drainOut("nowd", 2'b01);
`endif
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      checkOutput("wd err cleared", 32'(err_o), 32'h0);

      // Reset while draining a requester 0 job that also raised a bubble error.
      applyStimulus(2'b01, 2'b00, 16'h4001, 16'h0000);
      tick();
      checkOutput("rst grant", 32'(grant_o), 32'h1);
      applyStimulus(2'b00, 2'b00, 16'h4001, 16'h0000);
      tick();
      checkOutput("rst err", 32'(err_o), 32'h1);
      applyStimulus(2'b01, 2'b01, 16'h4002, 16'h0000);
      tick();
      checkOutput("rst word4002", 32'(core_data_o), 32'h4002);
      applyStimulus(2'b11, 2'b00, 16'h0a05, 16'h0b05);
      tick();
      checkOutput("rst pre grant", 32'(grant_o), 32'h1);
      #2;
      rst_ni = 1'b0;
      #1;
      checkReset("async rst");
      tick();
      tick();
      rst_ni = 1'b1;
      checkOutput("rst released grant", 32'(grant_o), 32'h0);
      tick();
      checkOutput("rst prio grant", 32'(grant_o), 32'h1);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
